// File: rtl/ibex_perf_pkg.sv
// Shared definitions for the performance-counter control stage: CSR addresses,
// event indices, slot numbering and address decode helpers.
package ibex_perf_pkg;

  localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
  localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] CSR_MHPMEVENT3    = 12'h323;

  localparam int unsigned SlotCycle   = 0;
  localparam int unsigned SlotInstret = 2;
  localparam int unsigned FirstHpm    = 3;

  typedef enum logic [3:0] {
    EvCycle       = 4'd0,
    EvInstrRet    = 4'd1,
    EvLoad        = 4'd2,
    EvStore       = 4'd3,
    EvJump        = 4'd4,
    EvBranch      = 4'd5,
    EvBranchTaken = 4'd6,
    EvCompressed  = 4'd7,
    EvLsuStall    = 4'd8,
    EvIfStall     = 4'd9,
    EvMulWait     = 4'd10,
    EvDivWait     = 4'd11
  } perf_event_e;

  typedef enum logic [2:0] {
    CsrIllegal,
    CsrCntLo,
    CsrCntHi,
    CsrInhibit,
    CsrEvent
  } csr_kind_e;

  function automatic logic slot_implemented(int unsigned slot, int unsigned num_counters);
    return (slot == SlotCycle) || (slot == SlotInstret) ||
           ((slot >= FirstHpm) && (slot < FirstHpm + num_counters));
  endfunction

  // Slot 1 (time) has no counter in this array, so its low/high CSRs are illegal.
  function automatic csr_kind_e csr_decode(logic [11:0] addr);
    csr_kind_e kind;
    kind = CsrIllegal;
    if (addr[11:5] == CSR_MCYCLE[11:5]) begin
      kind = (addr[4:0] == 5'd1) ? CsrIllegal : CsrCntLo;
    end else if (addr[11:5] == CSR_MCYCLEH[11:5]) begin
      kind = (addr[4:0] == 5'd1) ? CsrIllegal : CsrCntHi;
    end else if (addr[11:5] == CSR_MCOUNTINHIBIT[11:5]) begin
      if (addr[4:0] == CSR_MCOUNTINHIBIT[4:0]) begin
        kind = CsrInhibit;
      end else if (addr[4:0] >= CSR_MHPMEVENT3[4:0]) begin
        kind = CsrEvent;
      end
    end
    return kind;
  endfunction

  function automatic logic [31:0] inhibit_wmask(int unsigned num_counters);
    logic [31:0] m;
    m = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      m[i] = slot_implemented(i, num_counters);
    end
    return m;
  endfunction

endpackage

// File: rtl/ibex_perf_event_sel.sv
// One counter slot: holds its event mask (fixed or writable) and gates the
// increment by mask match, inhibit and a same-cycle write to the counter.
module ibex_perf_event_sel
  import ibex_perf_pkg::*;
#(
  parameter int unsigned          NumEvents   = 16,
  parameter bit                   Implemented = 1'b0,
  parameter bit                   Writable    = 1'b0,
  parameter logic [NumEvents-1:0] FixedMask   = '0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NumEvents-1:0] event_q_i,
  input  logic                 mask_we_i,
  input  logic [NumEvents-1:0] mask_wdata_i,
  input  logic                 inhibit_i,
  input  logic                 wr_suppress_i,
  output logic [NumEvents-1:0] mask_o,
  output logic                 inc_o
);

  logic [NumEvents-1:0] mask_q, mask_d;

  assign mask_d = (Writable && mask_we_i) ? mask_wdata_i : mask_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mask_q <= '0;
    end else begin
      mask_q <= mask_d;
    end
  end

  assign mask_o = Writable ? mask_q : FixedMask;

  // A counter write in the same cycle wins over the increment.
  assign inc_o = Implemented & (|(event_q_i & mask_o)) & ~inhibit_i & ~wr_suppress_i;

endmodule

// File: rtl/ibex_perf_counter_ctrl.sv
// CSR decode and strobe generation in front of the performance-counter array.
// Requests are registered; the response and write strobes appear one cycle later.
module ibex_perf_counter_ctrl
  import ibex_perf_pkg::*;
#(
  parameter int unsigned MaxNumCounters = 32,
  parameter int unsigned NumCounters    = 0,
  parameter int unsigned NumEvents      = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         csr_req_i,
  input  logic                         csr_we_i,
  input  logic [11:0]                  csr_addr_i,
  input  logic [31:0]                  csr_wdata_i,
  input  logic [NumEvents-1:0]         event_i,
  input  logic [MaxNumCounters*64-1:0] counter_val_i,
  output logic                         csr_rvalid_o,
  output logic [31:0]                  csr_rdata_o,
  output logic                         csr_illegal_o,
  output logic [MaxNumCounters-1:0]    counter_inc_o,
  output logic [MaxNumCounters-1:0]    counter_we_o,
  output logic [MaxNumCounters-1:0]    counterh_we_o,
  output logic [31:0]                  counter_val_o
);

  localparam logic [MaxNumCounters-1:0] InhibitWMask =
      MaxNumCounters'(inhibit_wmask(NumCounters));

  logic                      req_q;
  logic                      we_q;
  logic [11:0]               addr_q;
  logic [31:0]               wdata_q;
  logic [NumEvents-1:0]      event_q;
  logic [MaxNumCounters-1:0] inhibit_q, inhibit_d;

  csr_kind_e            kind;
  logic [4:0]           idx;
  logic                 wr_valid;
  logic                 wr_lo;
  logic                 wr_hi;
  logic                 wr_event;
  logic [63:0]          slot_val;
  logic [31:0]          rdata;
  logic [NumEvents-1:0] evt_mask [MaxNumCounters];

  assign kind     = csr_decode(addr_q);
  assign idx      = addr_q[4:0];
  assign wr_valid = req_q & we_q & (kind != CsrIllegal);
  assign wr_lo    = wr_valid && (kind == CsrCntLo);
  assign wr_hi    = wr_valid && (kind == CsrCntHi);
  assign wr_event = wr_valid && (kind == CsrEvent);

  assign inhibit_d = (wr_valid && (kind == CsrInhibit)) ?
                     (wdata_q[MaxNumCounters-1:0] & InhibitWMask) : inhibit_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      event_q   <= '0;
      inhibit_q <= '0;
    end else begin
      req_q     <= csr_req_i;
      we_q      <= csr_we_i;
      addr_q    <= csr_addr_i;
      wdata_q   <= csr_wdata_i;
      event_q   <= event_i;
      inhibit_q <= inhibit_d;
    end
  end

  for (genvar gi = 0; gi < MaxNumCounters; gi++) begin : g_slot
    localparam bit SlotImpl     = slot_implemented(gi, NumCounters);
    localparam bit SlotWritable = SlotImpl && (gi >= FirstHpm);
    localparam logic [NumEvents-1:0] SlotFixed =
        (gi == SlotCycle)   ? (NumEvents'(1) << EvCycle)    :
        (gi == SlotInstret) ? (NumEvents'(1) << EvInstrRet) : '0;

    assign counter_we_o[gi]  = SlotImpl && wr_lo && (idx == 5'(gi));
    assign counterh_we_o[gi] = SlotImpl && wr_hi && (idx == 5'(gi));

    ibex_perf_event_sel #(
      .NumEvents  (NumEvents),
      .Implemented(SlotImpl),
      .Writable   (SlotWritable),
      .FixedMask  (SlotFixed)
    ) u_event_sel (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .event_q_i    (event_q),
      .mask_we_i    (wr_event && (idx == 5'(gi))),
      .mask_wdata_i (wdata_q[NumEvents-1:0]),
      .inhibit_i    (inhibit_q[gi]),
      .wr_suppress_i(counter_we_o[gi] | counterh_we_o[gi]),
      .mask_o       (evt_mask[gi]),
      .inc_o        (counter_inc_o[gi])
    );
  end

  assign counter_val_o = (|(counter_we_o | counterh_we_o)) ? wdata_q : '0;

  // Counter reads see the array value before any write issued by this request.
  always_comb begin
    rdata    = '0;
    slot_val = counter_val_i[{idx, 6'd0} +: 64];
    case (kind)
      CsrCntLo: begin
        if (slot_implemented(32'(idx), NumCounters)) rdata = slot_val[31:0];
      end
      CsrCntHi: begin
        if (slot_implemented(32'(idx), NumCounters)) rdata = slot_val[63:32];
      end
      CsrInhibit: rdata = 32'(inhibit_q);
      CsrEvent:   rdata = 32'(evt_mask[idx]);
      default:    rdata = '0;
    endcase
  end

  assign csr_rvalid_o  = req_q;
  assign csr_rdata_o   = req_q ? rdata : '0;
  assign csr_illegal_o = req_q && (kind == CsrIllegal);

endmodule
